mult_div: RTL
=============

# mult_div

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It executes mult, multu, div and divu over a fixed multi-cycle latency. It handles mthi and mtlo writes and holds the HI/LO registers that mfhi and mflo read. Its Busy output is the Busy_E signal the hazard/stall unit uses to hold md-class instructions in D.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles after the start cycle for mult/multu.
- DIV_CYCLES, default 10: busy cycles after the start cycle for div/divu.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- ins_E  in  32  instruction currently in E (bubble = 32'h0).
- A  in  32  forwarded rs value in E.
- B  in  32  forwarded rt value in E.
- HI  out  32  HI register value, read by mfhi in E.
- LO  out  32  LO register value, read by mflo in E.
- Busy  out  1  unit occupied; drives Busy_E of the stall unit.

## Operation
- Decode: opcode ins_E[31:26]==6'b000000 with one of these funct values:
  - mult 011000, multu 011001, div 011010, divu 011011: start an operation.
  - mthi 010001, mtlo 010011: register moves.
  - Any other instruction is ignored.
- Start = decoded mult/multu/div/divu in E while busy_q==0. A start while busy_q==1 is a protocol violation and is ignored; the stall unit prevents it.
- Busy = Start | busy_q. The output is combinational so the start cycle itself stalls D.
- On the start edge:
  - latch A, B and the op into internal registers;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - set busy_q.
- Each busy cycle decrements the counter. On the edge where counter==1:
  - write the result to HI/LO;
  - clear busy_q;
  - the counter goes to 0.
- Arithmetic:
  - mult: signed 32x32 to 64 product; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: same, unsigned.
  - Divide by zero: HI/LO unchanged; the unit still runs the full DIV_CYCLES.
- mthi: HI<=A at the end of its E cycle. mtlo: LO<=A at the end of its E cycle. These are single-cycle and never assert Busy. They are only issued when not busy, as guaranteed by the stall unit.
- Reset (including mid-operation): HI=0, LO=0, busy_q=0, counter=0; the pending result is discarded. Busy=0 during the reset cycle.

## Timing
- Reset values: HI=0, LO=0, Busy=0 (Start is masked while reset=1).
- Cycle 0: mult in E, Busy=1 combinationally.
- Cycles 1..N (N=MULT_CYCLES or DIV_CYCLES): Busy=1 from busy_q.
- Edge ending cycle N: HI/LO updated.
- Cycle N+1: Busy=0, and an mfhi/mflo held in D is released. Busy is high for N+1 cycles total.
- HI/LO outputs change only at clock edges; there is no combinational path from A/B to HI/LO.
- Back-to-back: a new mult may enter E at cycle N+2 at the earliest, because the stall unit releases D at N+1.
- Counter width is ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)): 4 bits at the defaults.

## Structure
- Shared package holds:
  - SPECIAL opcode;
  - funct constants MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO (the stall unit uses the same constants);
  - md_op_t enum {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}.
- One natural sub-module: md_decode. It is combinational, maps ins_E to start/op/mthi/mtlo, and is reusable by the stall unit.
- The result is computed from the latched operands. Behavioural * and / / % on sign-qualified operands are acceptable; the latency is modelled by the counter, not by an iterative datapath.

## Test plan
- Reset, then idle: HI=0, LO=0, Busy=0 throughout.
- mult A=32'hFFFF_FFFE (-2), B=3: Busy high 6 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. multu with the same operands gives HI=2, LO=32'hFFFF_FFFA.
- div A=-7, B=2: Busy high 11 cycles, then LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). divu A=7, B=2 gives LO=3, HI=1.
- div by zero after mthi A=32'h1234 and mtlo A=32'h5678: Busy still high 11 cycles; HI=32'h1234 and LO=32'h5678 unchanged.
- mult started, reset asserted in busy cycle 3: Busy=0 and HI=LO=0 the next cycle; no later write occurs.
- mult issued while busy_q=1 (forced violation): ignored; the original result lands on schedule.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared decode constants and types for the multiply/divide unit and the stall unit.
package mult_div_pkg;

    localparam logic [5:0] SPECIAL = 6'b000000;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_op_t;

    // IDLE: no operation in flight. RUN: counting down the busy cycles.
    typedef enum logic {
        MD_IDLE,
        MD_RUN
    } md_state_t;

endpackage

// File: rtl/mult_div_if.sv
// E-stage signals between the pipeline (master) and the multiply/divide unit (slave).
// Busy semantics: Busy=1 means the unit is occupied (including its start cycle);
// the stall unit must hold any md-class instruction in D while Busy=1, and a
// start presented while the unit is already running is ignored.
interface mult_div_if;
    logic [31:0] ins_E;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;

    modport master (output ins_E, output A, output B,
                    input HI, input LO, input Busy);
    modport slave  (input ins_E, input A, input B,
                    output HI, output LO, output Busy);
endinterface

// File: rtl/mult_div_md_decode.sv
// Combinational decoder for md-class instructions; reusable by the stall unit.
module md_decode
    import mult_div_pkg::*;
(
    input  logic [31:0] ins,
    output logic        start,
    output md_op_t      op,
    output logic        mthi,
    output logic        mtlo
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = ins[31:26];
    assign funct         = ins[5:0];
    assign unused_fields = ^ins[25:6];

    // Classify the instruction from opcode and funct; anything else is ignored.
    always_comb begin
        start = 1'b0;
        op    = MD_MULT;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (opcode == SPECIAL) begin
            case (funct)
                MULT:    begin start = 1'b1; op = MD_MULT;  end
                MULTU:   begin start = 1'b1; op = MD_MULTU; end
                DIV:     begin start = 1'b1; op = MD_DIV;   end
                DIVU:    begin start = 1'b1; op = MD_DIVU;  end
                MTHI:    mthi = 1'b1;
                MTLO:    mtlo = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit holding HI/LO; latency is modelled by a down-counter.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  md,
    output md_state_t  state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic             dec_start;
    md_op_t           dec_op;
    logic             dec_mthi;
    logic             dec_mtlo;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, b_q;
    md_op_t           op_q;
    logic [31:0]      hi_q, lo_q;

    logic             start;
    logic             finish;
    logic             res_we;
    logic [31:0]      res_hi, res_lo;

    md_decode u_decode (
        .ins   (md.ins_E),
        .start (dec_start),
        .op    (dec_op),
        .mthi  (dec_mthi),
        .mtlo  (dec_mtlo)
    );

    // A start is only accepted when idle and never during reset.
    assign start        = dec_start && (state_q == MD_IDLE) && !reset;
    assign md.Busy      = !reset && (start || (state_q == MD_RUN));
    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    assign state_dbg    = state_q;

    // Next-state and counter: load on start, count down while running, finish at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_RUN;
                    cnt_d   = ((dec_op == MD_DIV) || (dec_op == MD_DIVU))
                              ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Result from the latched operands; a zero divisor suppresses the write.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b1;
        case (op_q)
            MD_MULT:  {res_hi, res_lo} = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
            MD_MULTU: {res_hi, res_lo} = {32'b0, a_q} * {32'b0, b_q};
            MD_DIV: begin
                if (b_q == 32'b0) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_q);
                    res_hi = $signed(a_q) % $signed(b_q);
                end
            end
            MD_DIVU: begin
                if (b_q == 32'b0) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    // State, counter and operand latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MD_MULT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                a_q  <= md.A;
                b_q  <= md.B;
                op_q <= dec_op;
            end
        end
    end

    // HI/LO: result write on the final busy edge, otherwise mthi/mtlo moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (finish) begin
            if (res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else begin
            if (dec_mthi) hi_q <= md.A;
            if (dec_mtlo) lo_q <= md.A;
        end
    end

endmodule
